// File: rtl/and_event_counter_pkg.sv
// and_event_pkg: shared types and defaults for the AND event counter slice.
//   evt_state_e : qualification FSM state (IDLE=00, QUAL=01, ACTIVE=10)
//   DEF_CNT_W   : default event counter width
//   DEF_HOLD    : default number of consecutive high samples per event
package and_event_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    QUAL   = 2'b01,
    ACTIVE = 2'b10
  } evt_state_e;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_HOLD  = 3;
endpackage

// File: rtl/and_event_counter_if.sv
// and_event_counter_if: control, sample input and status outputs of the
// AND event counter.
//   en, clr, y_in          : driven by the master (upstream / control)
//   event_pulse, active,
//   count[CNT_W], sat      : driven by the slave (the counter block)
interface and_event_counter_if
  import and_event_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             en;
  logic             clr;
  logic             y_in;
  logic             event_pulse;
  logic             active;
  logic [CNT_W-1:0] count;
  logic             sat;

  modport master (output en, clr, y_in, input event_pulse, active, count, sat);
  modport slave  (input en, clr, y_in, output event_pulse, active, count, sat);
endinterface

// File: rtl/and_event_counter_sat_counter.sv
// sat_counter: W-bit saturating up-counter with a sticky all-ones flag.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of q and sat (wins over inc)
//   inc        : count one event
//   q          : event count, holds at all-ones
//   sat        : set on the edge q reaches all-ones, cleared by clr/reset
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat
);
  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (inc && q != MAX) begin
      q <= q + 1'b1;
      if (q == MAX - 1'b1) sat <= 1'b1;
    end
  end
endmodule

// File: rtl/and_event_counter.sv
// and_event_counter: qualifies the upstream reduction-AND output as an event
// once it has been high for HOLD consecutive samples, emits a one-cycle
// event_pulse per high run and counts events in a saturating counter.
//   clk, rst_n : clock, async active-low reset
//   bus.slave  : en, clr, y_in in; event_pulse, active, count, sat out
// Optional: define AND_EVT_SYNC_EN to pass y_in through a 2-flop
// synchronizer (adds 2 cycles of latency) for asynchronous upstream sources.
module and_event_counter
  import and_event_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int HOLD  = DEF_HOLD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  and_event_counter_if.slave   bus
);
  localparam int             RW       = $clog2(HOLD + 1);
  localparam logic [RW-1:0]  RUN_LAST = RW'(HOLD - 1);

  evt_state_e    state;
  logic [RW-1:0] run;
  logic          y_s;
  logic          fire;

`ifdef AND_EVT_SYNC_EN
  logic [1:0] y_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_sync <= '0;
    else        y_sync <= {y_sync[0], bus.y_in};
  end
  assign y_s = y_sync[1];
`else
  assign y_s = bus.y_in;
`endif

  // This edge samples the HOLD-th consecutive high (IDLE covers HOLD==1).
  assign fire = bus.en & y_s &
                ((state == IDLE && HOLD == 1) || (state == QUAL && run == RUN_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      run             <= '0;
      bus.event_pulse <= 1'b0;
      bus.active      <= 1'b0;
    end else begin
      bus.event_pulse <= 1'b0;
      // Any break in the qualifying run (clr, en low, y low) returns to IDLE;
      // clr also swallows a coincident event.
      if (bus.clr || !bus.en || !y_s) begin
        state      <= IDLE;
        run        <= '0;
        bus.active <= 1'b0;
      end else if (fire) begin
        state           <= ACTIVE;
        run             <= '0;
        bus.active      <= 1'b1;
        bus.event_pulse <= 1'b1;
      end else if (state == IDLE) begin
        state <= QUAL;
        run   <= RW'(1);
      end else if (state == QUAL) begin
        run <= run + 1'b1;
      end
      // ACTIVE with en&y high: hold, no re-trigger.
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clr),
    .inc   (fire & ~bus.clr),
    .q     (bus.count),
    .sat   (bus.sat)
  );
endmodule

// File: tb/tb_and_event_counter.sv
// Bench: two instances (CNT_W=8 and CNT_W=2, HOLD=3) share stimulus and are
// checked each cycle against a streak-based behavioural model.
module tb_and_event_counter;
  localparam int HOLD = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  and_event_counter_if #(.CNT_W(8)) bus0 ();
  and_event_counter_if #(.CNT_W(2)) bus1 ();

  and_event_counter #(.CNT_W(8), .HOLD(HOLD)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  and_event_counter #(.CNT_W(2), .HOLD(HOLD)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic en = 1'b1, clr = 1'b0, y = 1'b1;
  assign bus0.en = en;  assign bus0.clr = clr;  assign bus0.y_in = y;
  assign bus1.en = en;  assign bus1.clr = clr;  assign bus1.y_in = y;

  int n_cmp = 0, n_bad = 0;
  int pulses1 = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: event = en&y high streak reaching exactly HOLD; active while the
  // streak is at least HOLD; count is min(events since clear, max).
  int  m_streak;
  bit  m_pulse, m_active;
  int  m_cnt[2];
  bit  m_sat[2];
  bit  sy1, sy2;
  int  mx[2] = '{255, 3};

  always @(posedge clk or negedge rst_n) begin
    bit ys;
    if (!rst_n) begin
      m_streak = 0; m_pulse = 0; m_active = 0;
      m_cnt = '{0, 0}; m_sat = '{0, 0};
      sy1 = 0; sy2 = 0;
    end else begin
`ifdef AND_EVT_SYNC_EN
      ys = sy2; sy2 = sy1; sy1 = y;
`else
      ys = y;
`endif
      if (clr || !en || !ys) m_streak = 0;
      else                   m_streak = m_streak + 1;
      m_pulse  = (m_streak == HOLD);
      m_active = (m_streak >= HOLD);
      for (int i = 0; i < 2; i++) begin
        if (clr)          m_cnt[i] = 0;
        else if (m_pulse) m_cnt[i] = (m_cnt[i] < mx[i]) ? m_cnt[i] + 1 : mx[i];
        m_sat[i] = (m_cnt[i] == mx[i]);
      end
    end
  end

  always @(negedge clk) begin
    chk("pulse0",  bus0.event_pulse, m_pulse);
    chk("active0", bus0.active,      m_active);
    chk("count0",  bus0.count,       m_cnt[0]);
    chk("sat0",    bus0.sat,         m_sat[0]);
    chk("pulse1",  bus1.event_pulse, m_pulse);
    chk("active1", bus1.active,      m_active);
    chk("count1",  bus1.count,       m_cnt[1]);
    chk("sat1",    bus1.sat,         m_sat[1]);
    if (bus1.event_pulse) pulses1++;
  end

  task automatic cyc(input logic e, input logic c, input logic yy);
    en = e; clr = c; y = yy;
    @(posedge clk); #1;
  endtask

  initial begin
    int p0;
    // Reset with y high: everything zero.
    #12;
    chk("rst_pulse",  bus0.event_pulse, 0);
    chk("rst_active", bus0.active,      0);
    chk("rst_count",  bus0.count,       0);
    chk("rst_sat",    bus0.sat,         0);
    rst_n = 1'b1;

    // First run of three highs -> one event.
    cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 1);
`ifndef AND_EVT_SYNC_EN
    chk("first_pulse",  bus0.event_pulse, 1);
    chk("first_count",  bus0.count,       1);
    chk("first_active", bus0.active,      1);
    chk("model_pin_pulse", 16'(m_pulse), 1);
`endif
    // Held high: no re-trigger.
    for (int i = 0; i < 7; i++) cyc(1, 0, 1);
`ifndef AND_EVT_SYNC_EN
    chk("held_count", bus0.count, 1);
    chk("held_pulse", bus0.event_pulse, 0);
`endif
    cyc(1, 0, 0); cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 1);
`ifndef AND_EVT_SYNC_EN
    chk("second_count", bus0.count, 2);
    chk("model_pin_cnt", 16'(m_cnt[0]), 2);
`endif

    // Short runs: 2 high, 1 low, 2 high -> nothing.
    cyc(1, 1, 0);
    cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 0); cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 0);
`ifndef AND_EVT_SYNC_EN
    chk("short_count", bus0.count, 0);
`endif

    // Saturation on the 2-bit instance: five events.
    p0 = pulses1;
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 0);
`ifndef AND_EVT_SYNC_EN
      if (k == 2) chk("sat_at_3rd", bus1.sat, 1);
`endif
    end
    cyc(1, 0, 0); cyc(1, 0, 0);
    chk("sat_count1",  bus1.count, 3);
    chk("sat_flag1",   bus1.sat,   1);
    chk("sat_pulses",  16'(pulses1 - p0), 5);
    chk("sat_count0",  bus0.count, 5);
    cyc(1, 1, 0);
    chk("clr_count1", bus1.count, 0);
    chk("clr_sat1",   bus1.sat,   0);

    // clr on the 3rd high sample kills the event.
    cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 1, 1);
`ifndef AND_EVT_SYNC_EN
    chk("coll_pulse",  bus0.event_pulse, 0);
    chk("coll_count",  bus0.count,       0);
    chk("coll_active", bus0.active,      0);
`endif
    // en dropped mid-qualification restarts the run.
    cyc(1, 0, 0); cyc(1, 0, 1); cyc(1, 0, 1); cyc(0, 0, 1); cyc(1, 0, 1); cyc(1, 0, 1);
`ifndef AND_EVT_SYNC_EN
    chk("en_drop_pulse", bus0.event_pulse, 0);
    chk("en_drop_count", bus0.count,       0);
`endif
    cyc(1, 0, 1);
`ifndef AND_EVT_SYNC_EN
    chk("en_resume_pulse", bus0.event_pulse, 1);
`endif

    // Async reset while ACTIVE: outputs drop without a clock edge.
    cyc(1, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_active", bus0.active,      0);
    chk("arst_pulse",  bus0.event_pulse, 0);
    chk("arst_count",  bus0.count,       0);
    chk("arst_count1", bus1.count,       0);
    #1 rst_n = 1'b1;

    // Randomized traffic with occasional clear and mid-cycle reset.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom % 20) != 0, ($urandom % 40) == 0, ($urandom % 10) < 7);
      if (($urandom % 400) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
